serv_csr_seq: RTL and testbench

Sequencer and arbiter for the bit-serial CSR datapath. Accepts CSR-instruction, trap-entry and MRET requests, grants one at a time with a fixed priority, and drives the serial pass that feeds the CSR unit. It generates the enable, bit-position strobes, CSR select enables, trap/mret qualifiers and the interrupt-sample trigger. It sits between the decode/control stage and the CSR unit.

---
 rtl/serv_csr_seq.sv | 113 +++++++++++
 tb/tb_serv_csr_seq.sv | 140 ++++++++++++++
 2 files changed

// File: rtl/serv_csr_seq.sv
// serv_csr_seq: sequencer and arbiter for the bit-serial CSR datapath.
// It arbitrates CSR, trap-entry and MRET requests with a fixed priority
// (trap > mret > csr). It then runs the serial pass that drives the CSR unit.
//
// Ports:
//   i_clk, i_rst         clock, asynchronous active-high reset
//   i_csr_req/i_csr_sel  CSR access request and its CSR class (latched at grant)
//   i_trap_req           trap entry request
//   i_mret_req           MRET request
//   i_hold               stall; freezes an active pass
//   o_busy               any non-idle state
//   o_ack                one-cycle completion pulse for the granted request
//   o_en                 datapath enable (pass active, not held)
//   o_cnt*               bit-position strobes for the current W-bit window
//   o_mstatus_en/o_mie_en/o_mcause_en  CSR select enables during a CSR pass
//   o_trap, o_mret       trap pass / MRET cycle qualifiers
//   o_trig_irq           interrupt-sample trigger, pulses in the grant cycle
module serv_csr_seq #(
    parameter int W = 1  // bits per cycle: 1 or 4
) (
    input  logic       i_clk,
    input  logic       i_rst,
    input  logic       i_csr_req,
    input  logic [1:0] i_csr_sel,
    input  logic       i_trap_req,
    input  logic       i_mret_req,
    input  logic       i_hold,
    output logic       o_busy,
    output logic       o_ack,
    output logic       o_en,
    output logic       o_cnt0to3,
    output logic       o_cnt3,
    output logic       o_cnt7,
    output logic       o_cnt11,
    output logic       o_cnt12,
    output logic       o_cnt_done,
    output logic       o_mstatus_en,
    output logic       o_mie_en,
    output logic       o_mcause_en,
    output logic       o_trap,
    output logic       o_mret,
    output logic       o_trig_irq
);

    typedef enum logic [1:0] {IDLE, CSR, TRAP, MRET} state_t;

    state_t     state, state_nxt;
    logic [4:0] cnt;
    logic [1:0] sel;

    logic [5:0] lo, hi;   // bit window [lo, hi] handled this cycle
    logic       pass;     // serial pass in progress
    logic       step;     // pass advances this cycle
    logic       done;
    logic       any_req;

    // True when bit b falls inside the current window.
    function automatic logic covers(input logic [5:0] a, input logic [5:0] z, input int b);
        return (a <= 6'(b)) && (z >= 6'(b));
    endfunction

    assign lo      = {1'b0, cnt};
    assign hi      = lo + 6'(W - 1);
    assign pass    = (state == CSR) || (state == TRAP);
    assign step    = pass && !i_hold;
    assign done    = (hi == 6'd31);
    assign any_req = i_trap_req || i_mret_req || i_csr_req;

    assign o_busy       = (state != IDLE);
    assign o_en         = step;
    assign o_cnt0to3    = step && (lo <= 6'd3);
    assign o_cnt3       = step && covers(lo, hi, 3);
    assign o_cnt7       = step && covers(lo, hi, 7);
    assign o_cnt11      = step && covers(lo, hi, 11);
    assign o_cnt12      = step && covers(lo, hi, 12);
    assign o_cnt_done   = step && done;
    assign o_ack        = (step && done) || (state == MRET);
    assign o_mstatus_en = (state == CSR) && (sel == 2'b01);
    assign o_mie_en     = (state == CSR) && (sel == 2'b10);
    assign o_mcause_en  = (state == CSR) && (sel == 2'b11);
    assign o_trap       = (state == TRAP);
    assign o_mret       = (state == MRET);
    // Only request-to-output path; gated so it stays low while in reset.
    assign o_trig_irq   = (state == IDLE) && !i_rst && any_req;

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: begin
                if (i_trap_req)      state_nxt = TRAP;
                else if (i_mret_req) state_nxt = MRET;
                else if (i_csr_req)  state_nxt = CSR;
            end
            CSR, TRAP: if (step && done) state_nxt = IDLE;
            MRET:      state_nxt = IDLE;
            default:   state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state <= IDLE;
            cnt   <= '0;
            sel   <= '0;
        end else begin
            state <= state_nxt;
            if (state == IDLE && any_req) sel <= i_csr_sel;
            // Natural 5-bit wrap lands on 0 exactly at the last window.
            if (step) cnt <= cnt + 5'(W);
        end
    end

endmodule

// File: tb/tb_serv_csr_seq.sv
// Randomized bench for serv_csr_seq: runs a W=1 and a W=4 instance side by
// side, each with its own requesters. It compares all outputs every cycle
// against a beat-counting transaction model.
module tb_serv_csr_seq;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    logic       csr_req [2];
    logic       trap_req[2];
    logic       mret_req[2];
    logic       hold    [2];
    logic [1:0] csr_sel [2];
    logic [14:0] ov     [2];

    genvar g;
    generate
        for (g = 0; g < 2; g++) begin : g_dut
            logic busy, ack, en, c03, c3, c7, c11, c12, cdone;
            logic mst, mie, mca, trap, mret, trig;
            serv_csr_seq #(.W(g == 0 ? 1 : 4)) u_dut (
                .i_clk(clk), .i_rst(rst),
                .i_csr_req(csr_req[g]), .i_csr_sel(csr_sel[g]),
                .i_trap_req(trap_req[g]), .i_mret_req(mret_req[g]),
                .i_hold(hold[g]),
                .o_busy(busy), .o_ack(ack), .o_en(en),
                .o_cnt0to3(c03), .o_cnt3(c3), .o_cnt7(c7), .o_cnt11(c11),
                .o_cnt12(c12), .o_cnt_done(cdone),
                .o_mstatus_en(mst), .o_mie_en(mie), .o_mcause_en(mca),
                .o_trap(trap), .o_mret(mret), .o_trig_irq(trig)
            );
            assign ov[g] = {busy, ack, en, c03, c3, c7, c11, c12, cdone,
                            mst, mie, mca, trap, mret, trig};
        end
    endgenerate

    // Model: kind 0 idle, 1 csr, 2 trap, 3 mret; k = completed beats of pass.
    int kind[2], k[2], msel[2], dropk[2];
    int wv[2] = '{1, 4};
    int passed = 0, total = 0;

    task automatic chk(input string tag, input logic [14:0] obs, input logic [14:0] exp);
        total++;
        if (obs === exp) passed++;
        else $display("FAIL %s: got %b want %b", tag, obs, exp);
    endtask

    function automatic logic [14:0] model_out(input int i);
        int  w    = wv[i];
        int  p    = 32 / w;
        bit  ps   = (kind[i] == 1) || (kind[i] == 2);
        bit  en   = ps && !hold[i];
        bit  any  = trap_req[i] || mret_req[i] || csr_req[i];
        bit  last = en && (k[i] == p - 1);
        return {kind[i] != 0, last || kind[i] == 3, en,
                en && (k[i] <= 3 / w), en && (k[i] == 3 / w), en && (k[i] == 7 / w),
                en && (k[i] == 11 / w), en && (k[i] == 12 / w), last,
                kind[i] == 1 && msel[i] == 1, kind[i] == 1 && msel[i] == 2,
                kind[i] == 1 && msel[i] == 3, kind[i] == 2, kind[i] == 3,
                kind[i] == 0 && any};
    endfunction

    task automatic model_step(input int i);
        int p = 32 / wv[i];
        if (kind[i] == 0) begin
            msel[i] = csr_sel[i];
            k[i]    = 0;
            if (trap_req[i])      kind[i] = 2;
            else if (mret_req[i]) kind[i] = 3;
            else if (csr_req[i])  kind[i] = 1;
        end else if (kind[i] == 3) begin
            dropk[i] = 3;
            kind[i]  = 0;
        end else if (!hold[i]) begin
            if (k[i] == p - 1) begin
                dropk[i] = kind[i];
                kind[i]  = 0;
            end else k[i]++;
        end
    endtask

    initial begin
        rst = 1'b1;
        for (int i = 0; i < 2; i++) begin
            csr_req[i] = 1'b1; trap_req[i] = 1'b1; mret_req[i] = 1'b1;
            hold[i] = 1'b0; csr_sel[i] = 2'b01;
            kind[i] = 0; k[i] = 0; msel[i] = 0; dropk[i] = 0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) chk("reset_outputs", ov[i], 15'd0);
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            csr_req[i] = 1'b0; trap_req[i] = 1'b0; mret_req[i] = 1'b0;
        end
        rst = 1'b0;

        for (int cyc = 0; cyc < 6000; cyc++) begin
            @(negedge clk);
            rst = 1'b0;
            for (int i = 0; i < 2; i++) begin
                if (dropk[i] == 1) csr_req[i] = 1'b0;
                if (dropk[i] == 2) trap_req[i] = 1'b0;
                if (dropk[i] == 3) mret_req[i] = 1'b0;
                dropk[i] = 0;
                // Granted request may drop mid-pass; pass must still complete.
                if (kind[i] == 1 && $urandom_range(0, 39) == 0) csr_req[i] = 1'b0;
                if (kind[i] == 2 && $urandom_range(0, 39) == 0) trap_req[i] = 1'b0;
                if (!trap_req[i] && $urandom_range(0, 59) == 0) trap_req[i] = 1'b1;
                if (!mret_req[i] && $urandom_range(0, 29) == 0) mret_req[i] = 1'b1;
                if (!csr_req[i] && $urandom_range(0, 9) == 0) begin
                    csr_req[i] = 1'b1;
                    csr_sel[i] = 2'($urandom_range(0, 3));
                end
                hold[i] = ($urandom_range(0, 4) == 0);
            end
            #1;
            for (int i = 0; i < 2; i++) begin
                logic [14:0] m;
                // Strobe lines are left unchecked in the single MRET cycle.
                m = (kind[i] == 3) ? 15'b111_000000_111111 : 15'h7fff;
                chk(i == 0 ? "cycle_w1" : "cycle_w4", ov[i] & m, model_out(i) & m);
            end
            if (cyc % 311 == 157) begin
                rst = 1'b1;
                #1;
                for (int i = 0; i < 2; i++) begin
                    chk("async_reset", ov[i], 15'd0);
                    kind[i] = 0; k[i] = 0; msel[i] = 0;
                end
            end else begin
                for (int i = 0; i < 2; i++) model_step(i);
            end
        end
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
